// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared definitions for the GPIO controller.
//   - Register word offsets within the GPIO page (GPIO_DATA_OUT .. GPIO_STATUS).
//   - Byte-lane write-mask expansion helper.
//   - Default input synchronizer depth.
//   - Arm-counter FSM state type (used when GPIO_CTRL_IRQ_EN is defined).
package gpio_ctrl_pkg;

  localparam logic [3:0] GPIO_DATA_OUT = 4'd0;
  localparam logic [3:0] GPIO_SET      = 4'd1;
  localparam logic [3:0] GPIO_CLR      = 4'd2;
  localparam logic [3:0] GPIO_TGL      = 4'd3;
  localparam logic [3:0] GPIO_DIR      = 4'd4;
  localparam logic [3:0] GPIO_DATA_IN  = 4'd5;
  localparam logic [3:0] GPIO_RISE_EN  = 4'd6;
  localparam logic [3:0] GPIO_FALL_EN  = 4'd7;
  localparam logic [3:0] GPIO_STATUS   = 4'd8;

  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    ARMING = 1'b0,
    ARMED  = 1'b1
  } arm_state_e;

  // Each byte-lane enable becomes eight identical bit enables.
  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: CPU IO-page bus toward the GPIO controller.
//   io_wstrb     write strobe, one cycle per write
//   io_rstrb     read strobe, one cycle per read
//   io_word_addr register word offset within the GPIO page
//   io_wdata     write data
//   io_wmask     byte-lane write enables
//   io_rdata     registered read data, valid the cycle after io_rstrb
// Modports: master (CPU side), slave (controller side).
interface gpio_ctrl_if;
  logic        io_wstrb;
  logic        io_rstrb;
  logic [3:0]  io_word_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wmask;
  logic [31:0] io_rdata;

  modport master (
    output io_wstrb, io_rstrb, io_word_addr, io_wdata, io_wmask,
    input  io_rdata
  );

  modport slave (
    input  io_wstrb, io_rstrb, io_word_addr, io_wdata, io_wmask,
    output io_rdata
  );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: multi-bit input synchronizer for the GPIO pins.
//   CLK, RESET  clock and synchronous active-high reset
//   pin_i       asynchronous pin levels
//   sync_o      pin levels after SYNC_STAGES flops
//   rise_o      sync & ~prev  (only with GPIO_CTRL_IRQ_EN)
//   fall_o      ~sync & prev  (only with GPIO_CTRL_IRQ_EN)
// Macro GPIO_CTRL_IRQ_EN adds the "prev" register and the edge outputs.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o
`ifdef GPIO_CTRL_IRQ_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

`ifdef GPIO_CTRL_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) prev_q <= '0;
    else       prev_q <= sync_o;
  end

  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller on the SOC IO page.
//   CLK, RESET  clock and synchronous active-high reset
//   bus         gpio_ctrl_if.slave: strobes, word address, wdata/wmask, rdata
//   gpio_in     asynchronous pin inputs
//   gpio_out    output data register (driven regardless of gpio_oe)
//   gpio_oe     output enables, 1 = drive
//   irq         registered level interrupt, OR of STATUS bits
// Register map: 0 DATA_OUT, 1 SET, 2 CLR, 3 TGL, 4 DIR, 5 DATA_IN,
//   6 RISE_EN, 7 FALL_EN, 8 STATUS (W1C). Other offsets read 0, ignore writes.
// Macro GPIO_CTRL_IRQ_EN: enables RISE_EN/FALL_EN/STATUS, edge detection,
//   arm counter and irq. Without it offsets 6-8 are unmapped and irq is 0.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [31:0] RESET_OUT   = 32'h0
) (
  input  logic             CLK,
  input  logic             RESET,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [31:0]      lane_m;
  logic [31:0]      wbits;
  logic [WIDTH-1:0] wsel;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_val;

  // Masked-off lanes contribute zero data, so SET/CLR/TGL/W1C leave them alone.
  assign lane_m = expand_mask(bus.io_wmask);
  assign wbits  = bus.io_wdata & lane_m;
  assign wsel   = lane_m[WIDTH-1:0];
  assign wval   = wbits[WIDTH-1:0];

`ifdef GPIO_CTRL_IRQ_EN
  localparam int CNT_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] rise_w, fall_w;
  logic [WIDTH-1:0] ren_q, ren_d;
  logic [WIDTH-1:0] fen_q, fen_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] evt;
  logic             irq_q;
  arm_state_e       arm_q;
  logic [CNT_W-1:0] cnt_q;
  logic             armed;
`endif

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RESET  (RESET),
    .pin_i  (gpio_in),
    .sync_o (sync_w)
`ifdef GPIO_CTRL_IRQ_EN
    ,
    .rise_o (rise_w),
    .fall_o (fall_w)
`endif
  );

  // Write decode
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
`ifdef GPIO_CTRL_IRQ_EN
    ren_d = ren_q;
    fen_d = fen_q;
    w1c   = '0;
`endif
    if (bus.io_wstrb) begin
      case (bus.io_word_addr)
        GPIO_DATA_OUT: out_d = (out_q & ~wsel) | wval;
        GPIO_SET:      out_d = out_q | wval;
        GPIO_CLR:      out_d = out_q & ~wval;
        GPIO_TGL:      out_d = out_q ^ wval;
        GPIO_DIR:      dir_d = (dir_q & ~wsel) | wval;
`ifdef GPIO_CTRL_IRQ_EN
        GPIO_RISE_EN:  ren_d = (ren_q & ~wsel) | wval;
        GPIO_FALL_EN:  fen_d = (fen_q & ~wsel) | wval;
        GPIO_STATUS:   w1c   = wval;
`endif
        default: ;
      endcase
    end
  end

`ifdef GPIO_CTRL_IRQ_EN
  // Edges are ignored until the synchronizer has filled with real pin levels.
  assign armed    = (arm_q == ARMED);
  assign evt      = armed ? ((rise_w & ren_q) | (fall_w & fen_q)) : '0;
  // A new event on a bit wins over a coincident W1C of that bit.
  assign status_d = (status_q & ~w1c) | evt;
`endif

  // Read mux: sees register contents before any same-cycle write.
  always_comb begin
    rd_val = '0;
    case (bus.io_word_addr)
      GPIO_DATA_OUT: rd_val = 32'(out_q);
      GPIO_DIR:      rd_val = 32'(dir_q);
      GPIO_DATA_IN:  rd_val = 32'(sync_w);
`ifdef GPIO_CTRL_IRQ_EN
      GPIO_RISE_EN:  rd_val = 32'(ren_q);
      GPIO_FALL_EN:  rd_val = 32'(fen_q);
      GPIO_STATUS:   rd_val = 32'(status_q);
`endif
      default:       rd_val = '0;
    endcase
  end

  assign rdata_d = bus.io_rstrb ? rd_val : rdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q   <= RESET_OUT[WIDTH-1:0];
      dir_q   <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef GPIO_CTRL_IRQ_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ren_q    <= '0;
      fen_q    <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ren_q    <= ren_d;
      fen_q    <= fen_d;
      status_q <= status_d;
      irq_q    <= |status_d;
    end
  end

  // Arm counter: SYNC_STAGES+1 cycles in ARMING after reset release.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      arm_q <= ARMING;
      cnt_q <= '0;
    end else if (arm_q == ARMING) begin
      if (cnt_q == CNT_W'(SYNC_STAGES)) arm_q <= ARMED;
      else                              cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign gpio_out     = out_q;
  assign gpio_oe      = dir_q;
  assign bus.io_rdata = rdata_q;

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Memory-mapped GPIO controller on the SOC IO page; owns the GPIO_OUT pins previously driven by a bare write register.
- Provides the following to firmware:
  - atomic SET/CLR/TOGGLE access
  - per-pin direction
  - synchronized input readback
  - sticky edge-interrupt status with W1C
- Sits between the CPU IO decode and the top-level GPIO pins; single-cycle writes, one-cycle registered reads.

Parameters:
- WIDTH, 32, number of GPIO pins (1..32).
- SYNC_STAGES, 2, input synchronizer depth (>=2).
- RESET_OUT, 32'h0, reset value of the output data register.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- io_wstrb  in  1  write strobe, one cycle per write.
- io_rstrb  in  1  read strobe, one cycle per read.
- io_word_addr  in  4  register word offset within GPIO page.
- io_wdata  in  32  write data.
- io_wmask  in  4  byte-lane write enables.
- io_rdata  out  32  read data, valid the cycle after io_rstrb.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  output data register.
- gpio_oe  out  WIDTH  output enables (1 = drive).
- irq  out  1  level interrupt, OR of enabled status bits.

Behaviour:
- Register map (word offset):
  - 0 DATA_OUT: RW.
  - 1 SET: W; out |= wdata.
  - 2 CLR: W; out &= ~wdata.
  - 3 TGL: W; out ^= wdata.
  - 4 DIR: RW.
  - 5 DATA_IN: RO, synchronized.
  - 6 RISE_EN: RW.
  - 7 FALL_EN: RW.
  - 8 STATUS: R/W1C.
- Offsets 1-3 read 0. Offsets 9-15: writes ignored, reads return 0.
- Byte lanes: only lanes with io_wmask[i]=1 participate. For SET/CLR/TGL/W1C, masked-off lanes are treated as wdata=0. Bits >= WIDTH are ignored on write and read as 0.
- Write latency: the register updates at the clock edge sampling io_wstrb. gpio_out/gpio_oe change the next cycle.
- Read latency:
  - io_rdata is registered, loaded on the edge sampling io_rstrb.
  - io_rdata holds its value until the next io_rstrb.
  - Read and write to the same offset in the same cycle return the pre-write value.
- Simultaneous io_wstrb and io_rstrb are legal and independent.
- Input path:
  - SYNC_STAGES-flop synchronizer, then one "prev" register.
  - DATA_IN reflects a pin change SYNC_STAGES cycles later.
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - STATUS[i] is set by rise|fall; latency is SYNC_STAGES+1 cycles from the pin edge.
- W1C vs. event: if an event and a W1C hit the same bit in the same cycle, set wins; no event is lost.
- irq: registered, equals |STATUS_next, so it becomes visible in the same cycle as the status bit.
- Clearing the last status bit deasserts irq the cycle after the write.
- Writes to RISE_EN/FALL_EN do not alter STATUS. Clearing an enable does not clear pending status.
- Arm counter:
  - After RESET deasserts, a counter runs SYNC_STAGES+1 cycles; edge detection is disarmed until it expires.
  - This prevents spurious events from the pipeline filling with pin levels.
  - FSM states: ARMING (counting) -> ARMED (counter expired).
  - RESET in any state returns to ARMING with count 0.
- Reset values:
  - gpio_out = RESET_OUT[WIDTH-1:0].
  - gpio_oe = 0; all enables and STATUS = 0.
  - io_rdata = 0; irq = 0; synchronizer and prev = 0.
- Reset mid-operation: a write strobe coincident with RESET is discarded; reset has priority over all updates.
- gpio_out drives its value regardless of gpio_oe. Tristating is done at the top level using gpio_oe.

Optional Feature:
- Macro: GPIO_CTRL_IRQ_EN.
- Defined: RISE_EN/FALL_EN/STATUS registers, edge detection, arm counter and irq are implemented as above.
- Undefined:
  - Offsets 6-8 behave as unmapped (read 0, writes ignored).
  - irq is tied to 0.
  - The prev register and arm counter are removed.
  - DATA_IN path is unchanged.

Decomposition:
- Shared package gpio_ctrl_pkg holds:
  - register offset localparams GPIO_DATA_OUT=0 through GPIO_STATUS=8;
  - byte-mask expansion function;
  - default SYNC_STAGES.
- One natural sub-module: gpio_sync (parameterized SYNC_STAGES multi-bit synchronizer plus prev register and rise/fall outputs), instantiated once.

Test Plan:
- Reset check: with RESET_OUT=0, hold RESET 3 cycles -> gpio_out=0, gpio_oe=0, irq=0, io_rdata=0.
- Masked write: write DATA_OUT=32'hDEADBEEF with wmask=4'hF, then CLR 32'h0000FF00, then SET 32'h00001000 with wmask=4'b0010 -> gpio_out=32'hDEAD10EF; read offset 0 returns 32'hDEAD10EF one cycle after io_rstrb.
- Toggle and unmapped: TGL 32'hFFFFFFFF on 32'hDEAD10EF -> 32'h2152EF10. Write offset 12 -> no change; read offsets 1 and 12 -> 0.
- Input sync: drive gpio_in=32'hA5A5A5A5 -> DATA_IN reads 0 before SYNC_STAGES cycles, then 32'hA5A5A5A5 after.
- Edge IRQ: RISE_EN=32'h1; toggle gpio_in[0] 0->1 -> STATUS=1 and irq=1 exactly SYNC_STAGES+1 cycles later. W1C 32'h1 -> irq=0 next cycle.
- Race and arming:
  - Rising edge on pin 0 timed to reach STATUS in the same cycle as a W1C of bit 0 -> STATUS[0]=1 and irq stays 1.
  - gpio_in held high across RESET release -> no STATUS bit set.
